count_seq_checker: RTL and testbench

Receive-side monitor for the two-bit counter stream. Samples a free-running count value each clock, locks onto the modulo-2^WIDTH increment sequence and reports sequence breaks and wrap events. Sits downstream of any `two_bit_counter`-style source as its consumer and checker, in the design and on the bench.

---
 rtl/count_chk_pkg.sv | 20 ++
 rtl/sat_counter.sv | 25 ++
 rtl/count_seq_checker.sv | 133 +++++++++++++
 tb/tb_count_seq_checker.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/count_chk_pkg.sv
// Shared types and helpers for the count sequence checker.
package count_chk_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 2;
  localparam int DEF_STAT_W = 8;

  // Increment modulo 2^width (width below 32).
  function automatic logic [31:0] next_count(input logic [31:0] value, input int unsigned width);
    logic [31:0] mask;
    mask = (32'h1 << width) - 32'h1;
    return (value + 32'h1) & mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int width = 8
) (
  input  logic             c,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [width-1:0] cnt
);

  // Count register: clear, saturating increment, or hold.
  always_ff @(posedge c or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {width{1'b1}})) begin
      cnt <= cnt + {{(width-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/count_seq_checker.sv
// Locks onto a modulo-2^WIDTH increment stream and reports breaks and wraps.
// Optional COUNT_CHK_STICKY_EN adds a sticky error flag output err_sticky.
module count_seq_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = 2,
  parameter int STAT_W   = DEF_STAT_W
) (
  input  logic              c,
  input  logic              rst,
  input  logic [WIDTH-1:0]  q_in,
  input  logic              q_vld,
  input  logic              clr,
  output logic              locked,
  output logic              err_pulse,
  output logic [STAT_W-1:0] err_cnt,
  output logic [STAT_W-1:0] wrap_cnt,
`ifdef COUNT_CHK_STICKY_EN
  output logic              err_sticky,
`endif
  output logic [WIDTH-1:0]  exp_q
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0]    LOCK_GW = GW'(LOCK_CNT);
  localparam logic [WIDTH-1:0] Q_MAX   = {WIDTH{1'b1}};

  state_t           state_r, state_s;
  logic [GW-1:0]    good_r, good_s;
  logic [WIDTH-1:0] exp_q_r, exp_s, q_inc_s, exp_inc_s;
  logic             locked_r, err_pulse_r, err_s, wrap_s;

  // Next-state, expected-count and event decode.
  always_comb begin
    state_s   = state_r;
    good_s    = good_r;
    exp_s     = exp_q_r;
    err_s     = 1'b0;
    wrap_s    = 1'b0;
    q_inc_s   = WIDTH'(next_count(32'(q_in), WIDTH));
    exp_inc_s = WIDTH'(next_count(32'(exp_q_r), WIDTH));
    if (q_vld) begin
      case (state_r)
        HUNT: begin
          exp_s   = q_inc_s;
          good_s  = '0;
          state_s = SYNC;
        end
        SYNC: begin
          exp_s = q_inc_s;
          if (q_in == exp_q_r) begin
            good_s = good_r + 1'b1;
            if (good_s == LOCK_GW) begin
              state_s = LOCKED;
            end else begin
              state_s = SYNC;
            end
          end else begin
            good_s = '0;
          end
        end
        LOCKED: begin
          if (q_in == exp_q_r) begin
            exp_s  = exp_inc_s;
            wrap_s = (q_in == Q_MAX);
          end else begin
            err_s   = 1'b1;
            exp_s   = q_inc_s;
            good_s  = '0;
            state_s = SYNC;
          end
        end
        default: begin
          state_s = HUNT;
          good_s  = '0;
          exp_s   = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM and registered outputs.
  always_ff @(posedge c or negedge rst) begin
    if (!rst) begin
      state_r     <= HUNT;
      good_r      <= '0;
      exp_q_r     <= '0;
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      good_r      <= good_s;
      exp_q_r     <= exp_s;
      locked_r    <= (state_s == LOCKED);
      err_pulse_r <= err_s;
    end
  end

  sat_counter #(.width(STAT_W)) u_err_cnt (
    .c(c), .rst(rst), .clr(clr), .inc(err_s), .cnt(err_cnt)
  );

  sat_counter #(.width(STAT_W)) u_wrap_cnt (
    .c(c), .rst(rst), .clr(clr), .inc(wrap_s), .cnt(wrap_cnt)
  );

`ifdef COUNT_CHK_STICKY_EN
  logic err_sticky_r;

  // Sticky error flag; clear beats a coincident error.
  always_ff @(posedge c or negedge rst) begin
    if (!rst) begin
      err_sticky_r <= 1'b0;
    end else if (clr) begin
      err_sticky_r <= 1'b0;
    end else if (err_s) begin
      err_sticky_r <= 1'b1;
    end else begin
      err_sticky_r <= err_sticky_r;
    end
  end

  assign err_sticky = err_sticky_r;
`endif

  assign locked    = locked_r;
  assign err_pulse = err_pulse_r;
  assign exp_q     = exp_q_r;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed, table-driven bench for count_seq_checker (default and STAT_W=2 instances).
module tb_count_seq_checker;

  logic       c = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] q_in = 2'd0;
  logic       q_vld = 1'b0;
  logic       clr = 1'b0;

  logic       locked, err_pulse;
  logic [7:0] err_cnt, wrap_cnt;
  logic [1:0] exp_q;
  logic       locked2, err_pulse2;
  logic [1:0] err_cnt2, wrap_cnt2;
  logic [1:0] exp_q2;
`ifdef COUNT_CHK_STICKY_EN
  logic       err_sticky, err_sticky2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 c = ~c;

  count_seq_checker #(.WIDTH(2), .LOCK_CNT(2), .STAT_W(8)) dut (
    .c(c), .rst(rst), .q_in(q_in), .q_vld(q_vld), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt),
`ifdef COUNT_CHK_STICKY_EN
    .err_sticky(err_sticky),
`endif
    .exp_q(exp_q)
  );

  count_seq_checker #(.WIDTH(2), .LOCK_CNT(2), .STAT_W(2)) dut2 (
    .c(c), .rst(rst), .q_in(q_in), .q_vld(q_vld), .clr(clr),
    .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2), .wrap_cnt(wrap_cnt2),
`ifdef COUNT_CHK_STICKY_EN
    .err_sticky(err_sticky2),
`endif
    .exp_q(exp_q2)
  );

  typedef struct {
    logic       vld;
    logic [1:0] q;
    logic       cl;
    logic       lk;
    logic       ep;
    logic [7:0] ec;
    logic [7:0] wc;
    logic [1:0] eq;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present inputs, then sample 1 time unit after the capturing edge.
  task automatic drive(input logic v, input logic [1:0] q, input logic cl);
    q_vld = v;
    q_in  = q;
    clr   = cl;
    @(posedge c);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 2'd0, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    // locked stream, wrap at q=3, break 1,3, relock 0,1, idle, clr tests
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'd1};
    tbl[1]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'd2};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 2'd3};
    tbl[3]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 2'd0};
    tbl[4]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 2'd1};
    tbl[5]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 2'd2};
    tbl[6]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1, 2'd2};
    tbl[7]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1, 2'd0};
    tbl[8]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1, 2'd1};
    tbl[9]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1, 2'd2};
    tbl[10] = '{1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1, 2'd2};
    tbl[11] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1, 2'd3};
    tbl[12] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 2'd3};
    tbl[13] = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 2'd0};
    tbl[14] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 2'd1};

    do_reset();
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_err_pulse", 32'(err_pulse), 32'd0);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);
    chk("reset_wrap_cnt", 32'(wrap_cnt), 32'd0);
    chk("reset_exp_q", 32'(exp_q), 32'd0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].vld, tbl[i].q, tbl[i].cl);
      chk($sformatf("v%0d_locked", i), 32'(locked), 32'(tbl[i].lk));
      chk($sformatf("v%0d_err_pulse", i), 32'(err_pulse), 32'(tbl[i].ep));
      chk($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(tbl[i].ec));
      chk($sformatf("v%0d_wrap_cnt", i), 32'(wrap_cnt), 32'(tbl[i].wc));
      chk($sformatf("v%0d_exp_q", i), 32'(exp_q), 32'(tbl[i].eq));
    end

    // Idle cycles interleaved: 0,x,1,x,2 locks on the third valid sample.
    do_reset();
    drive(1'b1, 2'd0, 1'b0);
    drive(1'b0, 2'd2, 1'b0);
    chk("idle_exp_hold", 32'(exp_q), 32'd1);
    drive(1'b1, 2'd1, 1'b0);
    drive(1'b0, 2'd0, 1'b0);
    chk("idle_not_locked", 32'(locked), 32'd0);
    chk("idle_exp_hold2", 32'(exp_q), 32'd2);
    drive(1'b1, 2'd2, 1'b0);
    chk("idle_locked", 32'(locked), 32'd1);
    chk("idle_no_err", 32'(err_cnt), 32'd0);
    drive(1'b1, 2'd3, 1'b0);
    chk("idle_wrap", 32'(wrap_cnt), 32'd1);

    // Asynchronous reset between edges while locked.
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_locked", 32'(locked), 32'd0);
    chk("async_rst_wrap", 32'(wrap_cnt), 32'd0);
    chk("async_rst_exp_q", 32'(exp_q), 32'd0);
    chk("async_rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge c);
    #1;
    rst = 1'b1;
    drive(1'b1, 2'd0, 1'b0);
    drive(1'b1, 2'd1, 1'b0);
    chk("relock_not_yet", 32'(locked), 32'd0);
    drive(1'b1, 2'd2, 1'b0);
    chk("relock_locked", 32'(locked), 32'd1);

    // Saturation on the STAT_W=2 instance: five breaks, count holds at 3.
    do_reset();
    drive(1'b1, 2'd0, 1'b0);
    drive(1'b1, 2'd1, 1'b0);
    drive(1'b1, 2'd2, 1'b0);
    chk("sat_locked", 32'(locked2), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 2'd0, 1'b0);
      chk($sformatf("sat_pulse%0d", k), 32'(err_pulse2), 32'd1);
      chk($sformatf("sat_cnt%0d", k), 32'(err_cnt2), (k > 3) ? 32'd3 : 32'(k));
      drive(1'b1, 2'd1, 1'b0);
      chk($sformatf("sat_pulse_low%0d", k), 32'(err_pulse2), 32'd0);
      drive(1'b1, 2'd2, 1'b0);
    end
    drive(1'b1, 2'd0, 1'b1);
    chk("clr_with_break_pulse", 32'(err_pulse2), 32'd1);
    chk("clr_with_break_cnt", 32'(err_cnt2), 32'd0);

`ifdef COUNT_CHK_STICKY_EN
    do_reset();
    chk("sticky_reset", 32'(err_sticky), 32'd0);
    drive(1'b1, 2'd0, 1'b0);
    drive(1'b1, 2'd1, 1'b0);
    drive(1'b1, 2'd2, 1'b0);
    drive(1'b1, 2'd0, 1'b0);
    chk("sticky_set", 32'(err_sticky), 32'd1);
    drive(1'b1, 2'd1, 1'b0);
    drive(1'b1, 2'd2, 1'b0);
    chk("sticky_relock", 32'(locked), 32'd1);
    chk("sticky_hold", 32'(err_sticky), 32'd1);
    drive(1'b0, 2'd0, 1'b1);
    chk("sticky_clr", 32'(err_sticky), 32'd0);
    drive(1'b1, 2'd0, 1'b1);
    chk("sticky_clr_vs_err", 32'(err_sticky), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
